vedic_mac_seq: RTL and testbench

- Sequencer and accumulator that drives one shared signed 8x8 multiplier to compute an int8 dot product for TinyML kernels in the extended DLX datapath.
- Accepts a vector length on start, then consumes operand pairs over a valid/ready stream.
- Each pair is registered onto the multiplier inputs and the 16-bit product is sign-extended and accumulated.
- Presents the final sum with a valid/ready result handshake and a sticky overflow flag.

---
 rtl/vedic_mac_seq.sv | 119 +++++++++++
 tb/tb_vedic_mac_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mac_seq.sv
// Dot-product sequencer for one shared signed 8x8 multiplier.
// Operand pairs are registered onto the multiplier; products are accumulated one cycle later.
module vedic_mac_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             pend_q, pend_d;
  logic [7:0]       mul_a_q, mul_a_d;
  logic [7:0]       mul_b_q, mul_b_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic             xfer;
  logic             start_ok;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start_ok = (state_q == IDLE) && start;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RUN;
      RUN:     if (xfer && (cnt_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == RUN) && (cnt_q != '0);
    res_valid = (state_q == DONE);
  end

  assign prod_ext = ACC_W'($signed(mul_c));
  assign sum      = acc_q + prod_ext;
  assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;
    pend_d   = xfer;
    if (pend_q) begin
      acc_d = sum;
      if (add_ovf) ovf_d = 1'b1;
    end
    if (xfer) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
      cnt_d   = cnt_q - LEN_W'(1);
    end
    if (start_ok) begin
      cnt_d = len;
      acc_d = '0;
      ovf_d = 1'b0;
    end
    // Capture on DONE entry includes the product accumulated on that same edge.
    if ((state_d == DONE) && (state_q != DONE)) result_d = acc_d;
  end

  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_vedic_mac_seq.sv
// Bench for vedic_mac_seq: 32-bit and 16-bit accumulator instances share one stimulus stream,
// each checked against a plain-arithmetic dot-product model.
module tb_vedic_mac_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        res_ready = 1'b0;

  logic        busy32, in_ready32, res_valid32, ovf32;
  logic [7:0]  mul_a32, mul_b32;
  logic [15:0] mul_c32;
  logic [31:0] result32;
  logic        busy16, in_ready16, res_valid16, ovf16;
  logic [7:0]  mul_a16, mul_b16;
  logic [15:0] mul_c16;
  logic [15:0] result16;

  int checks = 0;
  int errors = 0;

  int pa[256];
  int pb[256];
  int exp32, exp16;
  bit eo32, eo16;

  int          obs_lat;
  logic [31:0] obs_res32;
  logic [15:0] obs_res16;
  logic        obs_ovf32, obs_ovf16;
  bit          obs_stable, obs_idle, obs_ready_bad, obs_busy_start, obs_ovf_clr, obs_timeout;

  always #5 clk = ~clk;

  assign mul_c32 = 16'($signed(mul_a32) * $signed(mul_b32));
  assign mul_c16 = 16'($signed(mul_a16) * $signed(mul_b16));

  vedic_mac_seq #(.LEN_W(8), .ACC_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy32),
    .in_valid(in_valid), .in_ready(in_ready32), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a32), .mul_b(mul_b32), .mul_c(mul_c32),
    .res_valid(res_valid32), .res_ready(res_ready), .result(result32), .ovf(ovf32)
  );

  vedic_mac_seq #(.LEN_W(8), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a16), .mul_b(mul_b16), .mul_c(mul_c16),
    .res_valid(res_valid16), .res_ready(res_ready), .result(result16), .ovf(ovf16)
  );

  // Reference: running wrapped sum; overflow whenever the exact step leaves the signed range.
  task automatic model(input int n);
    longint t;
    int s32 = 0;
    int s16 = 0;
    eo32 = 1'b0;
    eo16 = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = longint'(s32) + longint'(pa[i] * pb[i]);
      if (t > 64'sd2147483647 || t < -64'sd2147483648) eo32 = 1'b1;
      s32 = int'(t);
      t = longint'(s16) + longint'(pa[i] * pb[i]);
      if (t > 32767 || t < -32768) eo16 = 1'b1;
      s16 = int'(shortint'(t));
    end
    exp32 = s32;
    exp16 = s16;
  endtask

  // Drives one job and records what was observed; the test tasks judge the observations.
  task automatic run_job(input int n, input int mode, input int rdelay,
                         input int spur_at, input int spur_len, input bit start_on_hs);
    int idx = 0;
    int c = 0;
    bit v;
    obs_timeout = 1'b0;
    obs_ready_bad = 1'b0;
    obs_stable = 1'b1;
    @(negedge clk);
    start = 1'b1;
    len = n[7:0];
    in_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    c = 1;
    start = 1'b0;
    obs_busy_start = busy32 && busy16;
    obs_ovf_clr = !ovf32 && !ovf16;
    while (!res_valid32) begin
      if (c > 2000) begin
        obs_timeout = 1'b1;
        break;
      end
      if (idx == n && (in_ready32 || in_ready16)) obs_ready_bad = 1'b1;
      if (c == spur_at) begin
        start = 1'b1;
        len = spur_len[7:0];
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      v = v && (idx < n);
      in_valid = v;
      in_a = v ? pa[idx][7:0] : 8'($urandom);
      in_b = v ? pb[idx][7:0] : 8'($urandom);
      if (v && in_ready32) idx++;
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    obs_lat = c;
    obs_res32 = result32;
    obs_ovf32 = ovf32;
    obs_res16 = result16;
    obs_ovf16 = ovf16;
    if (!res_valid16) obs_stable = 1'b0;
    for (int k = 0; k < rdelay; k++) begin
      @(negedge clk);
      if (!res_valid32 || !res_valid16 || result32 !== obs_res32 || result16 !== obs_res16 ||
          ovf32 !== obs_ovf32 || ovf16 !== obs_ovf16) obs_stable = 1'b0;
    end
    res_ready = 1'b1;
    start = start_on_hs;
    len = 8'd7;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    obs_idle = !busy32 && !busy16 && !res_valid32 && !res_valid16 &&
               result32 === obs_res32 && result16 === obs_res16;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy32, in_ready32, res_valid32, ovf32, mul_a32, mul_b32, result32} !== '0 ||
        {busy16, in_ready16, res_valid16, ovf16, mul_a16, mul_b16, result16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b rv=%b ovf=%b ma=%h mb=%h res=%h / res16=%h, want all zero",
               busy32, in_ready32, res_valid32, ovf32, mul_a32, mul_b32, result32, result16);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    pa[0] = 1;   pb[0] = 2;
    pa[1] = -3;  pb[1] = 4;
    pa[2] = 127; pb[2] = -128;
    model(3);
    run_job(3, 0, 2, -1, 0, 1'b0);
    checks++;
    if (obs_res32 !== 32'(-16266)) begin errors++; $display("FAIL basic_res32: got %0d want -16266", $signed(obs_res32)); end
    checks++;
    if (obs_res16 !== 16'(exp16) || obs_ovf16 !== eo16) begin errors++; $display("FAIL basic_res16: got %0d/%b want %0d/%b", $signed(obs_res16), obs_ovf16, exp16, eo16); end
    checks++;
    if (obs_ovf32 !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", obs_ovf32); end
    checks++;
    if (obs_lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", obs_lat); end
    checks++;
    if (!obs_busy_start || !obs_idle || !obs_stable || obs_timeout) begin errors++; $display("FAIL basic_handshake: got busy=%b idle=%b stable=%b tmo=%b want 1 1 1 0", obs_busy_start, obs_idle, obs_stable, obs_timeout); end
  endtask

  task automatic test_len_zero;
    run_job(0, 0, 1, -1, 0, 1'b0);
    checks++;
    if (obs_res32 !== 32'd0 || obs_res16 !== 16'd0 || obs_ovf32 !== 1'b0 || obs_ovf16 !== 1'b0) begin
      errors++; $display("FAIL len0_result: got %0d/%0d ovf %b/%b want 0/0 ovf 0/0", $signed(obs_res32), $signed(obs_res16), obs_ovf32, obs_ovf16);
    end
    checks++;
    if (obs_lat !== 1) begin errors++; $display("FAIL len0_latency: got %0d want 1", obs_lat); end
    checks++;
    if (obs_ready_bad || !obs_idle) begin errors++; $display("FAIL len0_ready: got ready_seen=%b idle=%b want 0 1", obs_ready_bad, obs_idle); end
  endtask

  task automatic test_toggle_stall;
    for (int i = 0; i < 4; i++) begin pa[i] = -128; pb[i] = -128; end
    model(4);
    run_job(4, 1, 3, -1, 0, 1'b0);
    checks++;
    if (obs_res32 !== 32'd65536 || obs_ovf32 !== 1'b0) begin errors++; $display("FAIL toggle_res32: got %0d/%b want 65536/0", $signed(obs_res32), obs_ovf32); end
    checks++;
    if (obs_res16 !== 16'(exp16) || obs_ovf16 !== eo16) begin errors++; $display("FAIL toggle_res16: got %0d/%b want %0d/%b", $signed(obs_res16), obs_ovf16, exp16, eo16); end
    checks++;
    if (obs_lat !== 9) begin errors++; $display("FAIL toggle_latency: got %0d want 9", obs_lat); end
    checks++;
    if (obs_ready_bad || !obs_stable || !obs_idle) begin errors++; $display("FAIL toggle_hold: got ready_seen=%b stable=%b idle=%b want 0 1 1", obs_ready_bad, obs_stable, obs_idle); end
  endtask

  task automatic test_ovf16;
    pa[0] = -128; pb[0] = -128;
    pa[1] = -128; pb[1] = -128;
    run_job(2, 0, 1, -1, 0, 1'b0);
    checks++;
    if (obs_res16 !== 16'h8000 || obs_ovf16 !== 1'b1) begin errors++; $display("FAIL ovf16_wrap: got %h/%b want 8000/1", obs_res16, obs_ovf16); end
    checks++;
    if (obs_res32 !== 32'd32768 || obs_ovf32 !== 1'b0) begin errors++; $display("FAIL ovf16_res32: got %0d/%b want 32768/0", $signed(obs_res32), obs_ovf32); end
    pa[0] = 3; pb[0] = -2;
    run_job(1, 0, 0, -1, 0, 1'b0);
    checks++;
    if (!obs_ovf_clr || obs_ovf16 !== 1'b0 || obs_res16 !== 16'(-6)) begin errors++; $display("FAIL ovf_clear: got clr=%b ovf=%b res=%0d want 1 0 -6", obs_ovf_clr, obs_ovf16, $signed(obs_res16)); end
  endtask

  task automatic test_start_ignored;
    for (int i = 0; i < 6; i++) begin pa[i] = $urandom_range(0, 255) - 128; pb[i] = $urandom_range(0, 255) - 128; end
    model(6);
    run_job(6, 0, 1, 3, 2, 1'b1);
    checks++;
    if (obs_res32 !== 32'(exp32) || obs_res16 !== 16'(exp16)) begin errors++; $display("FAIL spur_start_res: got %0d/%0d want %0d/%0d", $signed(obs_res32), $signed(obs_res16), exp32, exp16); end
    checks++;
    if (obs_lat !== 8 || !obs_idle) begin errors++; $display("FAIL spur_start_flow: got lat=%0d idle=%b want 8 1", obs_lat, obs_idle); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1;
    len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 8'(40 + i);
      in_b = 8'(90 - i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy32, in_ready32, res_valid32, ovf32, mul_a32, mul_b32, result32} !== '0 ||
        {busy16, in_ready16, res_valid16, ovf16, mul_a16, mul_b16, result16} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b rdy=%b rv=%b ovf=%b ma=%h mb=%h res=%h, want all zero",
               busy32, in_ready32, res_valid32, ovf32, mul_a32, mul_b32, result32);
    end
    @(negedge clk);
    rst = 1'b0;
    pa[0] = 5; pb[0] = -7;
    run_job(1, 0, 0, -1, 0, 1'b0);
    checks++;
    if (obs_res32 !== 32'(-35) || obs_res16 !== 16'(-35) || obs_lat !== 3) begin
      errors++; $display("FAIL reset_restart: got %0d/%0d lat=%0d want -35/-35 lat=3", $signed(obs_res32), $signed(obs_res16), obs_lat);
    end
  endtask

  task automatic test_random;
    int n;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if (j % 2 == 1) begin
          pa[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
          pb[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
        end else begin
          pa[i] = $urandom_range(0, 255) - 128;
          pb[i] = $urandom_range(0, 255) - 128;
        end
      end
      model(n);
      run_job(n, 2, $urandom_range(0, 3), -1, 0, 1'b0);
      checks++;
      if (obs_res32 !== 32'(exp32) || obs_ovf32 !== eo32) begin errors++; $display("FAIL rand_res32[%0d]: got %0d/%b want %0d/%b", j, $signed(obs_res32), obs_ovf32, exp32, eo32); end
      checks++;
      if (obs_res16 !== 16'(exp16) || obs_ovf16 !== eo16) begin errors++; $display("FAIL rand_res16[%0d]: got %0d/%b want %0d/%b", j, $signed(obs_res16), obs_ovf16, exp16, eo16); end
      checks++;
      if (!obs_stable || !obs_idle || obs_ready_bad || obs_timeout) begin errors++; $display("FAIL rand_flow[%0d]: got stable=%b idle=%b ready_seen=%b tmo=%b want 1 1 0 0", j, obs_stable, obs_idle, obs_ready_bad, obs_timeout); end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_basic();
    test_len_zero();
    test_toggle_stall();
    test_ovf16();
    test_start_ignored();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
